pipe_ctrl: RTL and testbench

Pipelined successor to the single-cycle opcode controller for the 16-bit WISC core. Decodes the ID-stage opcode into the same control set (rf_re1/re2/we, op_lxb, op_sw, alu_alt_src, dm_rd/wr, mem_to_reg, hlt). Carries these control bits through ID/EX, EX/MEM and MEM/WB registers. Also owns load-use stall, branch flush, multi-cycle data-memory wait and halt drain. Sits between the IF/ID register and the datapath pipeline registers.

---
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: control-plane bundle between the WISC pipeline datapath and pipe_ctrl.
// Inputs to the controller: ID opcode/specifiers and the EX branch outcome.
// Outputs: PC/IF-ID enables and flush, per-stage control bits, forwarding rd/we, halt.
interface pipe_ctrl_if #(
  parameter int REGW = 4
);
  logic [3:0]      id_opcode;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic            ex_branch_taken;

  logic            pc_wr_en;
  logic            if_id_wr_en;
  logic            if_id_flush;
  logic            id_rf_re1;
  logic            id_rf_re2;
  logic            id_op_lxb;
  logic            id_op_sw;
  logic            ex_alu_alt_src;
  logic [REGW-1:0] ex_rd;
  logic [REGW-1:0] mem_rd;
  logic            ex_rf_we;
  logic            mem_rf_we;
  logic            mem_dm_rd_en;
  logic            mem_dm_wr_en;
  logic            wb_rf_we;
  logic            wb_mem_to_reg;
  logic [REGW-1:0] wb_rd;
  logic            halted;

  // Controller side
  modport slave (
    input  id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    output pc_wr_en, if_id_wr_en, if_id_flush,
    output id_rf_re1, id_rf_re2, id_op_lxb, id_op_sw,
    output ex_alu_alt_src, ex_rd, mem_rd, ex_rf_we, mem_rf_we,
    output mem_dm_rd_en, mem_dm_wr_en, wb_rf_we, wb_mem_to_reg, wb_rd, halted
  );

  // Datapath side
  modport master (
    output id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    input  pc_wr_en, if_id_wr_en, if_id_flush,
    input  id_rf_re1, id_rf_re2, id_op_lxb, id_op_sw,
    input  ex_alu_alt_src, ex_rd, mem_rd, ex_rf_we, mem_rf_we,
    input  mem_dm_rd_en, mem_dm_wr_en, wb_rf_we, wb_mem_to_reg, wb_rd, halted
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: WISC pipeline controller - ID decode, ID/EX -> EX/MEM -> MEM/WB control
//   registers, load-use stall, branch flush, data-memory wait and halt drain.
// Latency: ID decode reaches wb_* after 3 clocks plus stall/wait cycles.
// Backpressure: mem wait freezes every stage; load-use and drain gate PC and IF/ID.
// Ports: clk, rst_n (async active-low), bus (pipe_ctrl_if.slave).
module pipe_ctrl #(
  parameter int REGW    = 4,
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef struct packed {
    logic            rf_we;
    logic            alu_alt_src;
    logic            dm_rd;
    logic            dm_wr;
    logic            mem_to_reg;
    logic            hlt;
    logic [REGW-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic            rf_we;
    logic            dm_rd;
    logic            dm_wr;
    logic            mem_to_reg;
    logic            hlt;
    logic [REGW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic            rf_we;
    logic            mem_to_reg;
    logic            hlt;
    logic [REGW-1:0] rd;
  } wb_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  ex_t    r_idex, w_idex_nxt, w_id_dec;
  mem_t   r_exmem, w_exmem_nxt;
  wb_t    r_memwb, w_memwb_nxt;
  state_t r_state, w_state_nxt;

  logic w_re1, w_re2, w_lxb, w_sw, w_ld, w_hlt, w_we;
  logic w_mem_wait, w_flush, w_lu, w_live;
  logic w_pc, w_ifid, w_ifflush;

  // Opcode decode
  assign w_re1 = (bus.id_opcode <= 4'hB) || (bus.id_opcode == 4'hE);
  assign w_re2 = (bus.id_opcode <= 4'h4) || (bus.id_opcode == 4'h9);
  assign w_we  = (bus.id_opcode <= 4'h8) || (bus.id_opcode == 4'hA) ||
                 (bus.id_opcode == 4'hB) || (bus.id_opcode == 4'hD);
  assign w_lxb = (bus.id_opcode == 4'hA) || (bus.id_opcode == 4'hB);
  assign w_sw  = (bus.id_opcode == 4'h9);
  assign w_ld  = (bus.id_opcode == 4'h8);
  assign w_hlt = (bus.id_opcode == 4'hF);

  always_comb begin
    w_id_dec             = '0;
    w_id_dec.rf_we       = w_we;
    w_id_dec.alu_alt_src = w_ld | w_sw;
    w_id_dec.dm_rd       = w_ld;
    w_id_dec.dm_wr       = w_sw;
    w_id_dec.mem_to_reg  = w_ld;
    w_id_dec.hlt         = w_hlt;
    w_id_dec.rd          = bus.id_rd;
  end

  // Data-memory wait: counts extra cycles an LW/SW spends in EX/MEM
  generate
    if (MEM_LAT > 1) begin : g_wait
      localparam int CW = $clog2(MEM_LAT);
      logic [CW-1:0] r_cnt;
      logic          w_mem_op;
      assign w_mem_op   = r_exmem.dm_rd | r_exmem.dm_wr;
      assign w_mem_wait = w_mem_op && (r_cnt < CW'(MEM_LAT - 1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_cnt <= '0;
        else if (w_mem_wait) r_cnt <= r_cnt + 1'b1;
        else                 r_cnt <= '0;
      end
    end else begin : g_nowait
      assign w_mem_wait = 1'b0;
    end
  endgenerate

  // Hazards; mem wait outranks flush, flush outranks the load-use stall
  assign w_flush = bus.ex_branch_taken && !w_mem_wait && (r_state != S_HALTED);
  assign w_lu    = (r_state == S_RUN) && r_idex.dm_rd && (r_idex.rd != '0) &&
                   ((w_re1 && (r_idex.rd == bus.id_rs)) ||
                    (w_re2 && (r_idex.rd == bus.id_rt)));

  // Bubble into ID/EX on flush, stall, or any time the FSM is not fetching
  assign w_idex_nxt = (w_flush || w_lu || (r_state != S_RUN)) ? '0 : w_id_dec;

  always_comb begin
    w_exmem_nxt            = '0;
    w_exmem_nxt.rf_we      = r_idex.rf_we;
    w_exmem_nxt.dm_rd      = r_idex.dm_rd;
    w_exmem_nxt.dm_wr      = r_idex.dm_wr;
    w_exmem_nxt.mem_to_reg = r_idex.mem_to_reg;
    w_exmem_nxt.hlt        = r_idex.hlt;
    w_exmem_nxt.rd         = r_idex.rd;
    w_memwb_nxt            = '0;
    w_memwb_nxt.rf_we      = r_exmem.rf_we;
    w_memwb_nxt.mem_to_reg = r_exmem.mem_to_reg;
    w_memwb_nxt.hlt        = r_exmem.hlt;
    w_memwb_nxt.rd         = r_exmem.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!w_mem_wait) begin
      r_idex  <= w_idex_nxt;
      r_exmem <= w_exmem_nxt;
      r_memwb <= w_memwb_nxt;
    end
  end

  // Halt FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc        = 1'b0;
    w_ifid      = 1'b0;
    w_ifflush   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_mem_wait) begin
          w_pc = 1'b0;
        end else if (w_flush) begin
          w_pc      = 1'b1;
          w_ifflush = 1'b1;
        end else if (!w_lu) begin
          w_pc   = 1'b1;
          w_ifid = 1'b1;
          if (w_hlt) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_mem_wait) begin
          w_pc = 1'b0;
        end else if (w_flush) begin
          // A redirect squashes the HLT that put us here
          w_pc        = 1'b1;
          w_ifflush   = 1'b1;
          w_state_nxt = S_RUN;
        end else if (r_memwb.hlt) begin
          w_state_nxt = S_HALTED;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  assign w_live = (r_state != S_HALTED);

  // Front-end enables and ID decode are forced low while reset is held
  assign bus.pc_wr_en    = rst_n & w_pc;
  assign bus.if_id_wr_en = rst_n & w_ifid;
  assign bus.if_id_flush = rst_n & w_ifflush;
  assign bus.id_rf_re1   = rst_n & w_re1;
  assign bus.id_rf_re2   = rst_n & w_re2;
  assign bus.id_op_lxb   = rst_n & w_lxb;
  assign bus.id_op_sw    = rst_n & w_sw;

  assign bus.ex_alu_alt_src = w_live & r_idex.alu_alt_src;
  assign bus.ex_rf_we       = w_live & r_idex.rf_we;
  assign bus.ex_rd          = w_live ? r_idex.rd : '0;
  assign bus.mem_rf_we      = w_live & r_exmem.rf_we;
  assign bus.mem_rd         = w_live ? r_exmem.rd : '0;
  assign bus.mem_dm_rd_en   = w_live & r_exmem.dm_rd;
  assign bus.mem_dm_wr_en   = w_live & r_exmem.dm_wr;
  assign bus.wb_rf_we       = w_live & r_memwb.rf_we;
  assign bus.wb_mem_to_reg  = w_live & r_memwb.mem_to_reg;
  assign bus.wb_rd          = w_live ? r_memwb.rd : '0;
  assign bus.halted         = (r_state == S_HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl, one instance with MEM_LAT=1
// and one with MEM_LAT=3 driven by the same ID/EX stream.
module tb_pipe_ctrl;
  localparam logic [3:0] ADD = 4'h0, LW = 4'h8, SW = 4'h9, NOP = 4'hC, HLT = 4'hF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  // Per-opcode expectations, bit n = opcode n
  logic [15:0] m_re1 = 16'h4FFF;
  logic [15:0] m_re2 = 16'h021F;
  logic [15:0] m_we  = 16'h2DFF;
  logic [15:0] m_lxb = 16'h0C00;
  logic [15:0] m_sw  = 16'h0200;
  logic [15:0] m_ld  = 16'h0100;
  logic [15:0] m_alt = 16'h0300;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.REGW(4)) b1 ();
  pipe_ctrl_if #(.REGW(4)) b3 ();

  pipe_ctrl #(.REGW(4), .MEM_LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipe_ctrl #(.REGW(4), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                     input logic [3:0] rd, input logic br);
    b1.id_opcode = op; b1.id_rs = rs; b1.id_rt = rt; b1.id_rd = rd; b1.ex_branch_taken = br;
    b3.id_opcode = op; b3.id_rs = rs; b3.id_rt = rt; b3.id_rd = rd; b3.ex_branch_taken = br;
  endtask

  // One clock: present inputs just after the edge, leave time to settle before checks
  task automatic cyc(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                     input logic [3:0] rd, input logic br);
    @(posedge clk);
    #1;
    drv(op, rs, rt, rd, br);
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  // LW rd=lw_rd, then op2 (rd=4); checks stall presence, bubble and LW writeback
  task automatic lu_case(input string tag, input logic [3:0] lw_rd, input logic [3:0] op2,
                         input logic [3:0] rs2, input logic [3:0] rt2, input logic stall);
    cyc(LW, 4'd1, 4'd0, lw_rd, 1'b0);
    cyc(op2, rs2, rt2, 4'd4, 1'b0);
    chk({tag, "_pc1"}, b1.pc_wr_en, !stall);
    chk({tag, "_ifid1"}, b1.if_id_wr_en, !stall);
    if (stall) cyc(op2, rs2, rt2, 4'd4, 1'b0);
    else       cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk({tag, "_pc2"}, b1.pc_wr_en, 1);
    chk({tag, "_exrd"}, b1.ex_rd, stall ? 32'd0 : 32'd4);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk({tag, "_wbwe"}, b1.wb_rf_we, 1);
    chk({tag, "_wbrd"}, b1.wb_rd, lw_rd);
    nops(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;

    // Reset state
    #1 rst_n = 1'b0;
    drv(ADD, 4'd1, 4'd2, 4'd1, 1'b0);
    #2;
    chk("rst_pc", b1.pc_wr_en, 0);
    chk("rst_ifid", b1.if_id_wr_en, 0);
    chk("rst_re1", b1.id_rf_re1, 0);
    chk("rst_exwe", b1.ex_rf_we, 0);
    chk("rst_wbwe", b1.wb_rf_we, 0);
    chk("rst_halted", b1.halted, 0);
    chk("rst_pc3", b3.pc_wr_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(NOP, 4'd0, 4'd0, 4'd0, 1'b0);

    // ADD, SUB, SLL stream: writeback 3 cycles after each is in ID
    for (int i = 0; i < 7; i++) begin
      op = (i == 0) ? ADD : (i == 1) ? 4'h1 : (i == 2) ? 4'h4 : NOP;
      cyc(op, 4'd1, 4'd2, 4'(i + 1), 1'b0);
      chk($sformatf("s1_pc_%0d", i), b1.pc_wr_en, 1);
      if (i >= 3 && i <= 5) begin
        chk($sformatf("s1_wbwe_%0d", i), b1.wb_rf_we, 1);
        chk($sformatf("s1_wbrd_%0d", i), b1.wb_rd, i - 2);
      end
      if (i == 6) chk("s1_wbwe_6", b1.wb_rf_we, 0);
    end

    // Decode sweep over opcodes 0..E following each through the stages
    for (int i = 0; i < 18; i++) begin
      op = (i < 15) ? 4'(i) : NOP;
      cyc(op, 4'd0, 4'd0, 4'd0, 1'b0);
      chk($sformatf("dec_pc_%0d", i), b1.pc_wr_en, 1);
      if (i < 15) begin
        chk($sformatf("dec_re1_%0d", i), b1.id_rf_re1, m_re1[i]);
        chk($sformatf("dec_re2_%0d", i), b1.id_rf_re2, m_re2[i]);
        chk($sformatf("dec_lxb_%0d", i), b1.id_op_lxb, m_lxb[i]);
        chk($sformatf("dec_sw_%0d", i), b1.id_op_sw, m_sw[i]);
      end
      if (i >= 1 && i < 16) begin
        chk($sformatf("ex_alt_%0d", i - 1), b1.ex_alu_alt_src, m_alt[i - 1]);
        chk($sformatf("ex_we_%0d", i - 1), b1.ex_rf_we, m_we[i - 1]);
      end
      if (i >= 2 && i < 17) begin
        chk($sformatf("mem_rd_%0d", i - 2), b1.mem_dm_rd_en, m_ld[i - 2]);
        chk($sformatf("mem_wr_%0d", i - 2), b1.mem_dm_wr_en, m_sw[i - 2]);
        chk($sformatf("mem_we_%0d", i - 2), b1.mem_rf_we, m_we[i - 2]);
      end
      if (i >= 3) begin
        chk($sformatf("wb_we_%0d", i - 3), b1.wb_rf_we, m_we[i - 3]);
        chk($sformatf("wb_m2r_%0d", i - 3), b1.wb_mem_to_reg, m_ld[i - 3]);
      end
    end
    nops(3);

    // Load-use hazards
    lu_case("lu_rs",    4'd3, ADD,   4'd3, 4'd5, 1'b1);
    lu_case("lu_r0",    4'd0, ADD,   4'd0, 4'd5, 1'b0);
    lu_case("lu_sll",   4'd3, 4'h4,  4'd3, 4'd1, 1'b1);
    lu_case("lu_sra",   4'd3, 4'h5,  4'd1, 4'd3, 1'b0);
    lu_case("lu_sw_rt", 4'd3, SW,    4'd1, 4'd3, 1'b1);
    nops(3);

    // MEM_LAT=3: SW then ADD
    cyc(SW, 4'd1, 4'd2, 4'd0, 1'b0);
    cyc(ADD, 4'd1, 4'd2, 4'd6, 1'b0);
    chk("ml_pc_c1", b3.pc_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ml_wr_c2", b3.mem_dm_wr_en, 1);
    chk("ml_pc_c2", b3.pc_wr_en, 0);
    chk("ml_ifid_c2", b3.if_id_wr_en, 0);
    chk("ml1_pc_c2", b1.pc_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ml_wr_c3", b3.mem_dm_wr_en, 1);
    chk("ml_pc_c3", b3.pc_wr_en, 0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ml_wr_c4", b3.mem_dm_wr_en, 1);
    chk("ml_pc_c4", b3.pc_wr_en, 1);
    chk("ml_wbwe_c4", b3.wb_rf_we, 0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ml_wr_c5", b3.mem_dm_wr_en, 0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ml_wbwe_c6", b3.wb_rf_we, 1);
    chk("ml_wbrd_c6", b3.wb_rd, 6);
    nops(3);

    // Taken branch in EX squashes HLT in ID
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    cyc(HLT, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("br_flush", b1.if_id_flush, 1);
    chk("br_pc", b1.pc_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("br_pc_after", b1.pc_wr_en, 1);
    chk("br_flush_off", b1.if_id_flush, 0);
    chk("br_bubble", b1.ex_rf_we, 0);
    nops(4);
    chk("br_halted", b1.halted, 0);
    chk("br_pc_late", b1.pc_wr_en, 1);

    // HLT after LW: LW retires, then halt
    cyc(LW, 4'd1, 4'd0, 4'd7, 1'b0);
    cyc(HLT, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("h_pc_c1", b1.pc_wr_en, 1);
    chk("h_re1", b1.id_rf_re1, 0);
    cyc(ADD, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("h_pc_c2", b1.pc_wr_en, 0);
    chk("h_ifid_c2", b1.if_id_wr_en, 0);
    cyc(ADD, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("h_wbwe_c3", b1.wb_rf_we, 1);
    chk("h_wbrd_c3", b1.wb_rd, 7);
    chk("h_m2r_c3", b1.wb_mem_to_reg, 1);
    cyc(ADD, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("h_halted_c4", b1.halted, 0);
    chk("h_wbwe_c4", b1.wb_rf_we, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(LW, 4'd1, 4'd0, 4'd5, 1'b0);
      chk($sformatf("h_halted_%0d", i), b1.halted, 1);
      chk($sformatf("h_pc_%0d", i), b1.pc_wr_en, 0);
      chk($sformatf("h_wbwe_%0d", i), b1.wb_rf_we, 0);
      chk($sformatf("h_dmrd_%0d", i), b1.mem_dm_rd_en, 0);
    end

    // Reset during a memory wait, then confirm the wait counter restarts
    @(posedge clk);
    #1 rst_n = 1'b0;
    drv(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(LW, 4'd1, 4'd0, 4'd2, 1'b0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rw_dmrd_c2", b3.mem_dm_rd_en, 1);
    chk("rw_pc_c2", b3.pc_wr_en, 0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rw_pc_c3", b3.pc_wr_en, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_pc", b3.pc_wr_en, 0);
    chk("rw_rst_ifid", b3.if_id_wr_en, 0);
    chk("rw_rst_dmrd", b3.mem_dm_rd_en, 0);
    chk("rw_rst_exwe", b3.ex_rf_we, 0);
    chk("rw_rst_halted", b3.halted, 0);
    chk("rw_rst_pc1", b1.pc_wr_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(SW, 4'd1, 4'd2, 4'd0, 1'b0);
    chk("rs_pc_c0", b3.pc_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rs_pc_c1", b3.pc_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rs_pc_c2", b3.pc_wr_en, 0);
    chk("rs_wr_c2", b3.mem_dm_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rs_pc_c3", b3.pc_wr_en, 0);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rs_pc_c4", b3.pc_wr_en, 1);
    chk("rs_wr_c4", b3.mem_dm_wr_en, 1);
    cyc(NOP, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("rs_wr_c5", b3.mem_dm_wr_en, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
